// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO on a valid/ready byte interface.
// Define UART_RX_PARITY_EN to receive 8E1 frames and expose o_parity_err.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_data,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    input  logic       i_clr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic          r_sync1, r_sync2, r_sync3;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic [7:0]    r_rx_byte;
    logic          r_frame_err, r_overrun;

    logic          w_fall, w_tick, w_stop_sample, w_stop_ok;
    logic          w_empty, w_full, w_pop, w_push;
    logic          w_overrun_set, w_frame_set, w_par_err;
    logic [AW:0]   w_rptr_nx;

    // Synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_data;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall        = r_sync3 & ~r_sync2;
    assign w_tick        = (r_cnt == '0);
    assign w_stop_sample = (r_state == S_STOP) && w_tick;
    assign w_stop_ok     = w_stop_sample && r_sync2 && !w_par_err;
    assign w_frame_set   = w_stop_sample && !r_sync2;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_cnt   <= FULL_LOAD;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_cnt <= FULL_LOAD;
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= FULL_LOAD;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is caught
                    if (w_tick) begin
                        r_state <= r_sync2 ? S_IDLE : S_WAIT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_sync2) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if ((r_state == S_DATA) && w_tick) begin
            r_shift <= {r_sync2, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_parity_set;

    always_ff @(posedge i_clk) begin
        if ((r_state == S_PARITY) && w_tick) begin
            r_par_bit <= r_sync2;
        end
    end

    assign w_par_err    = (^r_shift) ^ r_par_bit;
    assign w_parity_set = w_stop_sample && r_sync2 && w_par_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_parity_err <= 1'b0;
        end else if (w_parity_set) begin
            r_parity_err <= 1'b1;
        end else if (i_clr_err) begin
            r_parity_err <= 1'b0;
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign w_par_err = 1'b0;
`endif

    // FIFO: a pop frees a slot for a push in the same cycle even when full
    assign w_empty       = (r_wptr == r_rptr);
    assign w_full        = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop         = i_rx_ready && !w_empty;
    assign w_push        = w_stop_ok && (!w_full || w_pop);
    assign w_overrun_set = w_stop_ok && w_full && !w_pop;
    assign w_rptr_nx     = r_rptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rx_byte <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nx;
                r_rx_byte <= (w_push && (w_rptr_nx == r_wptr)) ? r_shift
                                                               : r_mem[w_rptr_nx[AW-1:0]];
            end else if (w_push && w_empty) begin
                r_rx_byte <= r_shift;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (i_clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_rx_byte   = r_rx_byte;
    assign o_rx_valid  = !w_empty;
    assign o_busy      = (r_state != S_IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_valid, busy, ferr, ovr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] rxq[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        int         exp_byte;
        int         exp_ferr;
    } vec_t;
    vec_t tbl[6];

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx_data   (rx),
        .o_rx_byte   (rx_byte),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (rdy),
        .o_busy      (busy),
        .o_frame_err (ferr),
        .o_overrun   (ovr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(perr),
`endif
        .i_clr_err   (clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && rx_valid && rdy) rxq.push_back(rx_byte);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic s, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == NB - 1) return s;
        return p;
    endfunction

    function automatic int q_at(input int i);
        if (i < rxq.size()) return int'(rxq[i]);
        return -1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        for (int i = 0; i < NB; i++) begin
            rx = frame_bit(d, p, s, i);
            tick(CPB);
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    int         off_busy, off_valid, nvalid;
    logic [7:0] vbyte;

    initial begin
        tbl[0] = '{8'h00, 1'b1, 1, 'h00, 0};
        tbl[1] = '{8'hFF, 1'b1, 1, 'hFF, 0};
        tbl[2] = '{8'h3C, 1'b1, 1, 'h3C, 0};
        tbl[3] = '{8'h81, 1'b1, 1, 'h81, 0};
        tbl[4] = '{8'h55, 1'b0, 0, -1,   1};
        tbl[5] = '{8'h7E, 1'b1, 1, 'h7E, 0};

        // Reset values
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("rst_byte", rx_byte, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
`ifdef UART_RX_PARITY_EN
        chk("rst_perr", perr, 0);
`endif

        // Single 0xA5 frame with cycle-accurate busy/valid observation
        rdy = 1'b1;
        rxq.delete();
        off_busy = -1; off_valid = -1; nvalid = 0; vbyte = '0;
        for (int off = 0; off < NB * CPB + 20; off++) begin
            if (off > 3 && !busy && off_busy < 0) off_busy = off;
            if (rx_valid) begin
                nvalid++;
                off_valid = off;
                vbyte = rx_byte;
            end
            rx = (off < NB * CPB) ? frame_bit(8'hA5, ^8'hA5, 1'b1, off / CPB) : 1'b1;
            tick(1);
        end
        chk("single_busy_fall", off_busy, 11 + CPB * (NB - 1));
        chk("single_valid_cycles", nvalid, 1);
        chk("single_valid_at", off_valid, 11 + CPB * (NB - 1));
        chk("single_byte", vbyte, 'hA5);
        chk("single_ferr", ferr, 0);
        chk("single_count", rxq.size(), 1);

        // Table of isolated frames
        foreach (tbl[i]) begin
            pulse_clr();
            rxq.delete();
            send_frame(tbl[i].data, ^tbl[i].data, tbl[i].stop);
            rx = 1'b1;
            tick(3 * CPB);
            chk($sformatf("vec%0d_count", i), rxq.size(), tbl[i].exp_n);
            chk($sformatf("vec%0d_byte", i), q_at(0), tbl[i].exp_byte);
            chk($sformatf("vec%0d_ferr", i), ferr, tbl[i].exp_ferr);
            chk($sformatf("vec%0d_ovr", i), ovr, 0);
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end

        // Back-to-back frames fill the FIFO, fifth overruns
        rdy = 1'b0;
        pulse_clr();
        rxq.delete();
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b1);
        rx = 1'b1;
        tick(40);
        chk("b2b_ovr", ovr, 1);
        chk("b2b_valid", rx_valid, 1);
        chk("b2b_head", rx_byte, 'h00);
        chk("b2b_ferr", ferr, 0);
        rdy = 1'b1;
        tick(10);
        chk("b2b_count", rxq.size(), 4);
        chk("b2b_q0", q_at(0), 'h00);
        chk("b2b_q1", q_at(1), 'hFF);
        chk("b2b_q2", q_at(2), 'h3C);
        chk("b2b_q3", q_at(3), 'h81);
        chk("b2b_valid_after", rx_valid, 0);

        // Start-bit glitch
        pulse_clr();
        rxq.delete();
        chk("glitch_ovr_clr", ovr, 0);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2);
        chk("glitch_busy_start", busy, 1);
        tick(12);
        chk("glitch_busy_end", busy, 0);
        tick(CPB * NB);
        chk("glitch_count", rxq.size(), 0);
        chk("glitch_ferr", ferr, 0);
        chk("glitch_ovr", ovr, 0);

        // Framing error followed by a break
        send_frame(8'h55, ^8'h55, 1'b0);
        tick(40);
        chk("break_busy", busy, 1);
        rx = 1'b1;
        tick(20);
        chk("break_ferr", ferr, 1);
        chk("break_busy_end", busy, 0);
        chk("break_count", rxq.size(), 0);
        send_frame(8'h12, ^8'h12, 1'b1);
        rx = 1'b1;
        tick(30);
        chk("after_break_count", rxq.size(), 1);
        chk("after_break_byte", q_at(0), 'h12);
        chk("after_break_ferr", ferr, 1);
        pulse_clr();
        tick(1);
        chk("clr_ferr", ferr, 0);

        // Reset during data bit 3 with a byte already buffered
        rdy = 1'b0;
        rxq.delete();
        send_frame(8'h5A, ^8'h5A, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("pre_rst_valid", rx_valid, 1);
        chk("pre_rst_byte", rx_byte, 'h5A);
        for (int off = 0; off < 4 * CPB + 8; off++) begin
            rx = frame_bit(8'h99, ^8'h99, 1'b1, off / CPB);
            tick(1);
        end
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_byte", rx_byte, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ferr", ferr, 0);
        chk("mid_rst_ovr", ovr, 0);
        rst = 1'b1;
        rx = 1'b1;
        tick(20);
        chk("post_rst_busy", busy, 0);
        rdy = 1'b1;
        send_frame(8'hC3, ^8'hC3, 1'b1);
        rx = 1'b1;
        tick(30);
        chk("post_rst_count", rxq.size(), 1);
        chk("post_rst_byte", q_at(0), 'hC3);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x01 with parity 0 is bad, 0x03 with parity 0 is good
        pulse_clr();
        rxq.delete();
        send_frame(8'h01, 1'b0, 1'b1);
        rx = 1'b1;
        tick(30);
        chk("par_bad_perr", perr, 1);
        chk("par_bad_count", rxq.size(), 0);
        chk("par_bad_ferr", ferr, 0);
        pulse_clr();
        tick(1);
        send_frame(8'h03, 1'b0, 1'b1);
        rx = 1'b1;
        tick(30);
        chk("par_good_perr", perr, 0);
        chk("par_good_count", rxq.size(), 1);
        chk("par_good_byte", q_at(0), 'h03);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the FPGA top level: the receive-side counterpart of the design's `tx_data` transmitter. It deserialises an 8N1 (optionally 8E1) frame from an asynchronous `rx_data` line and checks the start and stop bits. It buffers received bytes in a small FIFO and presents them on a valid/ready byte interface to the downstream command/data path, for example a loader feeding DDR2.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit (100 MHz / 115200 baud); minimum 8.
- `FIFO_DEPTH`, default 4: receive buffer entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `rx_data`  in  1  asynchronous serial input; idles high.
- `rx_byte`  out  8  head-of-FIFO byte.
- `rx_valid`  out  1  FIFO non-empty; `rx_byte` is valid.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid` and `rx_ready` are both high.
- `busy`  out  1  high while the FSM is not IDLE.
- `frame_err`  out  1  sticky; set when a stop bit is sampled low.
- `overrun`  out  1  sticky; set when a good frame arrives while the FIFO is full.
- `parity_err`  out  1  sticky; present only with `UART_RX_PARITY_EN`.
- `clr_err`  in  1  single-cycle pulse that clears all sticky flags.

## Operation
- **Input synchronisation:** `rx_data` passes through a 2-flop synchroniser. The synchroniser flops reset to 1.
- **Counters:** a bit counter `cnt` (width clog2(`CLKS_PER_BIT`)) and a bit index (0..7).
- **IDLE:**
  - On a synchronised 1→0 transition, load `cnt` and go to START.
- **START:**
  - Wait `CLKS_PER_BIT/2` cycles (integer division), then sample.
  - Sample 0: go to DATA.
  - Sample 1: treat as a glitch and return to IDLE. Nothing is flagged.
- **DATA:**
  - Sample every `CLKS_PER_BIT` cycles, 8 times, LSB first, into a shift register.
  - Then go to PARITY if enabled, otherwise STOP.
- **PARITY (macro only):**
  - Sample one bit. The parity of the 8 data bits XOR the parity bit must be 0 (even parity).
- **STOP:** sample after `CLKS_PER_BIT` cycles.
  - Sample 1 and no parity error: push the byte, or set `overrun` and drop the byte if the FIFO is full. Return to IDLE at mid-stop-bit.
  - Sample 1 with a parity error: set `parity_err`, drop the byte, go to IDLE.
  - Sample 0: set `frame_err`, drop the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until the synchronised line is 1, then go to IDLE. A break condition therefore yields exactly one `frame_err` event.
- **FIFO:** circular buffer with pointers one bit wider than the address. Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- **Sticky flags:** if `clr_err` coincides with a new set event, the set wins.
- **Reset:** asserting `rst` mid-frame aborts the frame, empties the FIFO and returns the FSM to IDLE.

## Timing
- **Reset values:** `rx_byte`=0, `rx_valid`=0, `busy`=0, `frame_err`=0, `overrun`=0, `parity_err`=0; FSM in IDLE; pointers at 0.
- **Start detection:** the falling edge on `rx_data` is seen 2–3 cycles later (synchroniser delay).
- **Sample points:** bit n is sampled at `CLKS_PER_BIT/2 + n·CLKS_PER_BIT` cycles after the detected edge, with the start bit at n=0.
- **Output latency:** `rx_valid` rises on the cycle after the stop-bit sample.
- **Read interface:** `rx_byte` is registered from FIFO storage. It changes only after a pop or when a push goes into an empty FIFO.
- **Back-to-back frames:** zero idle bits between frames are supported. The FSM returns to IDLE at mid-stop-bit and re-arms for the next start edge.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - The frame is start, 8 data bits, even parity, stop.
  - The PARITY state and the `parity_err` port exist.
- **`UART_RX_PARITY_EN` undefined:**
  - The frame is 8N1.
  - The PARITY state and the `parity_err` port are absent; STOP follows the eighth data bit.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.
- **Single frame:** send 0xA5 as 8N1 with `rx_ready`=1 → `rx_valid` pulses for one cycle with `rx_byte`=0xA5; `frame_err`=0; `busy` falls at mid-stop-bit.
- **Back-to-back, FIFO fill:** send 0x00, 0xFF, 0x3C, 0x81, 0x7E with no idle gaps and `rx_ready`=0 → the FIFO holds 0x00, 0xFF, 0x3C, 0x81; `overrun`=1; then `rx_ready`=1 drains those 4 bytes in order and `rx_valid`=0 afterwards.
- **Start glitch:** `rx_data` low for 4 cycles, then high → FSM returns to IDLE; no byte; no flags.
- **Framing error and break:** send 0x55 with stop bit 0, then hold the line low for 40 cycles, then high → `frame_err`=1 set once, no byte; the next 0x12 frame is received correctly; a `clr_err` pulse clears `frame_err` to 0.
- **Reset mid-frame:** drive `rst`=0 for 1 cycle during DATA bit 3 → all outputs return to their reset values; a following 0xC3 frame is received correctly.
- **Parity (macro defined):** send 0x01 with parity bit 0 → `parity_err`=1, byte dropped; send 0x03 with parity bit 0 → 0x03 delivered, no error.
